trig_out_gen: RTL and testbench

TRIG_OUT_GEN -- requirements
Module: trig_out_gen

---
 rtl/trig_out_gen.sv | 140 ++++++++++++++
 tb/tb_trig_out_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/trig_out_gen.sv
// trig_out_gen: turns counter threshold crossings, counter wraps and external
// button edges into single-cycle TriggerOut pulses. Each event has a mask bit,
// a re-arm holdoff counter and a sticky status flag; a saturating counter
// totals every pulse that is actually emitted.
module trig_out_gen (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [31:0] count_val,
  input  logic [31:0] threshold,
  input  logic        thresh_en,
  input  logic [3:0]  ext_evt,
  input  logic [7:0]  mask,
  input  logic [7:0]  holdoff,
  input  logic [7:0]  clear,
  output logic [15:0] trig_out,
  output logic [15:0] status,
  output logic [15:0] evt_count
);

  // Compare history: cur_q is the latest sample, prev_q the one before.
  logic [31:0] cur_q, cur_d;
  logic [31:0] prev_q, prev_d;
  logic        cur_vld_q, cur_vld_d;
  logic        prev_vld_q, prev_vld_d;

  // External lines: two synchroniser stages plus one delay stage for edges.
  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  ext_dly_q, ext_dly_d;

  // Event path.
  logic [7:0]  raw_evt;
  logic [7:0]  busy;
  logic [7:0]  trig_d, trig_q;
  logic [7:0]  status_d, status_q;

  // Pulse accounting.
  logic [3:0]  pop_cnt;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_d, cnt_q;

  // Next-state for the sample history and the external-line synchroniser.
  always_comb begin
    cur_d      = count_val;
    prev_d     = cur_q;
    cur_vld_d  = 1'b1;
    prev_vld_d = cur_vld_q;
    sync1_d    = ext_evt;
    sync2_d    = sync1_q;
    ext_dly_d  = sync2_q;
  end

  // Raw event detection; counter events wait until both samples are real.
  always_comb begin
    raw_evt = '0;
    if (cur_vld_q && prev_vld_q) begin
      raw_evt[0] = thresh_en && (prev_q <  threshold) && (cur_q >= threshold);
      raw_evt[1] = thresh_en && (prev_q >= threshold) && (cur_q <  threshold);
      raw_evt[2] = (prev_q == 32'hFFFF_FFFF) && (cur_q == 32'h0000_0000);
      raw_evt[3] = (prev_q == 32'h0000_0000) && (cur_q == 32'hFFFF_FFFF);
    end
    raw_evt[7:4] = sync2_q & ~ext_dly_q;
  end

  // Per-event gating: a masked or held-off event leaves no trace at all,
  // so the holdoff counter only reloads on a pulse that is really emitted.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_evt
      logic [7:0] hcnt_q, hcnt_d;

      assign busy[gi]   = (hcnt_q != 8'd0);
      assign trig_d[gi] = raw_evt[gi] & mask[gi] & ~busy[gi];

      // Reload on an emitted pulse, otherwise count down to zero.
      always_comb begin
        if (trig_d[gi]) begin
          hcnt_d = holdoff;
        end else if (busy[gi]) begin
          hcnt_d = hcnt_q - 8'd1;
        end else begin
          hcnt_d = hcnt_q;
        end
      end

      // Holdoff counter register.
      always_ff @(posedge sys_clk) begin
        if (reset) begin
          hcnt_q <= 8'd0;
        end else begin
          hcnt_q <= hcnt_d;
        end
      end
    end
  endgenerate

  // Sticky flags and the saturating total follow the visible pulses; a set
  // coinciding with a clear keeps the flag set.
  always_comb begin
    status_d = (status_q & ~clear) | trig_q;
    pop_cnt  = 4'd0;
    for (int i = 0; i < 8; i++) begin
      pop_cnt = pop_cnt + {3'd0, trig_q[i]};
    end
    cnt_sum = {1'b0, cnt_q} + {13'd0, pop_cnt};
    cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // All pipeline, pulse, flag and counter registers.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cur_q      <= 32'd0;
      prev_q     <= 32'd0;
      cur_vld_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      sync1_q    <= 4'd0;
      sync2_q    <= 4'd0;
      ext_dly_q  <= 4'd0;
      trig_q     <= 8'd0;
      status_q   <= 8'd0;
      cnt_q      <= 16'd0;
    end else begin
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      cur_vld_q  <= cur_vld_d;
      prev_vld_q <= prev_vld_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      ext_dly_q  <= ext_dly_d;
      trig_q     <= trig_d;
      status_q   <= status_d;
      cnt_q      <= cnt_d;
    end
  end

  assign trig_out  = {8'h00, trig_q};
  assign status    = {8'h00, status_q};
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_trig_out_gen.sv
// Directed bench for trig_out_gen: latency, crossings, wraps, masking,
// sticky clear priority, external edges with holdoff, reset behaviour and
// counter saturation. Expected values are hand-derived constants.
module tb_trig_out_gen;

  logic        sys_clk   = 1'b0;
  logic        reset     = 1'b1;
  logic [31:0] count_val = 32'd0;
  logic [31:0] threshold = 32'd100;
  logic        thresh_en = 1'b1;
  logic [3:0]  ext_evt   = 4'd0;
  logic [7:0]  mask      = 8'hFF;
  logic [7:0]  holdoff   = 8'd0;
  logic [7:0]  clear     = 8'd0;
  logic [15:0] trig_out;
  logic [15:0] status;
  logic [15:0] evt_count;

  int n_assert = 0;
  int n_fail   = 0;

  trig_out_gen dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .count_val (count_val),
    .threshold (threshold),
    .thresh_en (thresh_en),
    .ext_evt   (ext_evt),
    .mask      (mask),
    .holdoff   (holdoff),
    .clear     (clear),
    .trig_out  (trig_out),
    .status    (status),
    .evt_count (evt_count)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [31:0] v, input logic [3:0] e);
    reset     = 1'b1;
    count_val = v;
    ext_evt   = e;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  int last_hit;
  int n_pulse;

  initial begin
    // Reset state
    tick(); tick(); tick();
    check("rst_trig",   trig_out,  16'h0000);
    check("rst_status", status,    16'h0000);
    check("rst_count",  evt_count, 16'h0000);

    // Release with a value already above threshold: no spurious crossing
    do_reset(32'd500, 4'd0);
    tick(); check("rel_c1_trig", trig_out, 16'h0000);
    tick(); check("rel_c2_trig", trig_out, 16'h0000);
    tick(); check("rel_c3_trig", trig_out, 16'h0000);
    check("rel_status", status, 16'h0000);

    // Quiet start at 99
    do_reset(32'd99, 4'd0);
    tick(); tick(); tick(); tick();

    // Upward crossing 99 -> 100, two-edge latency, single cycle
    count_val = 32'd100;
    tick(); check("up_early", trig_out, 16'h0000);
    tick(); check("up_pulse", trig_out, 16'h0001);
    tick(); check("up_gone",  trig_out, 16'h0000);
    check("up_status", status,    16'h0001);
    check("up_count",  evt_count, 16'h0001);

    // Downward crossing 100 -> 50
    count_val = 32'd50;
    tick(); tick(); check("dn_pulse", trig_out, 16'h0002);
    tick(); check("dn_status", status,    16'h0003);
    check("dn_count",  evt_count, 16'h0002);

    // Clear during a bit0 pulse: set wins for bit0, bit1 clears
    count_val = 32'd150;
    tick(); tick(); check("clr_pulse", trig_out, 16'h0001);
    clear = 8'h03;
    tick(); check("clr_setwins", status, 16'h0001);
    check("clr_count", evt_count, 16'h0003);
    clear = 8'h01;
    tick(); check("clr_alone", status, 16'h0000);
    clear = 8'h00;

    // Wrap events combined with crossings (threshold 1)
    threshold = 32'd1;
    count_val = 32'hFFFF_FFFF;
    tick(); tick(); tick(); check("wr_quiet", trig_out, 16'h0000);
    count_val = 32'h0000_0000;
    tick(); tick(); check("wr_down", trig_out, 16'h0006);
    count_val = 32'hFFFF_FFFF;
    tick(); tick(); check("wr_up", trig_out, 16'h0009);

    // Threshold events disabled: only the wrap remains
    thresh_en = 1'b0;
    count_val = 32'h0000_0000;
    tick(); tick(); check("ten_off", trig_out, 16'h0004);

    // Masked wrap bit: only the crossing remains
    thresh_en = 1'b1;
    mask      = 8'hF7;
    count_val = 32'hFFFF_FFFF;
    tick(); tick(); check("mask_b3", trig_out, 16'h0001);
    tick(); check("mask_count",  evt_count, 16'h0009);
    check("mask_status", status, 16'h000F);
    mask  = 8'hFF;
    clear = 8'hFF;
    tick();
    clear = 8'h00;
    tick();

    // External edge: three-edge latency, held high gives one pulse
    ext_evt = 4'b0010;
    tick(); tick(); check("ext_early", trig_out, 16'h0000);
    tick(); check("ext_pulse", trig_out, 16'h0020);
    tick(); check("ext_held",  trig_out, 16'h0000);
    tick(); tick(); check("ext_held2", trig_out, 16'h0000);
    ext_evt = 4'b0000;
    tick(); tick(); tick();
    check("ext_count", evt_count, 16'd10);

    // Holdoff 4 with ext_evt[0] toggling every 2 cycles: pulses 8 apart
    holdoff  = 8'd4;
    last_hit = -1;
    n_pulse  = 0;
    for (int i = 0; i < 32; i++) begin
      ext_evt[0] = ((i % 4) < 2);
      tick();
      if (trig_out[4]) begin
        if (last_hit >= 0) check("ho_gap", i - last_hit, 8);
        else               check("ho_first", i, 2);
        last_hit = i;
        n_pulse++;
      end
      check("ho_other_bits", trig_out & 16'hFFEF, 16'h0000);
    end
    check("ho_npulse", n_pulse, 4);
    holdoff = 8'd0;
    ext_evt = 4'b0000;
    tick(); tick(); tick(); tick(); tick(); tick();
    check("ho_count", evt_count, 16'd14);

    // ext_evt already high at reset release: pulse three edges later
    do_reset(32'd0, 4'b0100);
    tick(); tick(); check("rsx_early", trig_out, 16'h0000);
    tick(); check("rsx_pulse", trig_out, 16'h0040);
    tick(); check("rsx_gone",  trig_out, 16'h0000);
    ext_evt = 4'b0000;

    // Saturation: 32767 wrap+crossing transitions give 0xFFFE pulses
    do_reset(32'd0, 4'd0);
    threshold = 32'd1;
    tick(); tick(); tick();
    for (int i = 0; i < 32767; i++) begin
      count_val = (i % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      tick();
    end
    tick(); tick(); tick(); tick();
    check("sat_preset", evt_count, 16'hFFFE);
    ext_evt = 4'b0001;
    tick();
    count_val = 32'h0000_0000;
    tick();
    tick(); check("sat_triple", trig_out, 16'h0016);
    tick(); check("sat_full", evt_count, 16'hFFFF);
    count_val = 32'hFFFF_FFFF;
    tick(); tick(); tick(); tick();
    check("sat_held", evt_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
